// File: rtl/csr_wport_arbiter.sv
// -----------------------------------------------------------------------------
// csr_wport_arbiter
//
// Shares the CSR register file's single write port between the CLINT trap
// sequencer (multi-beat bursts, strict priority, holds the port until its last
// beat) and the write-back stage (single-beat CSR-instruction writes). A WB
// write that cannot reach the port is parked in a one-entry buffer. The buffer
// is written out after the burst, so WB writes are never lost or reordered.
//
// Parameters
//   MAX_BURST        watchdog limit on trap-burst beats (2..15)
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   trap_*_i         trap sequencer beat (valid/addr/data/last)
//   wb_*_i           write-back CSR write (valid/addr/data)
//   wb_ready_o       WB write accepted this cycle
//   flush_i          discard the buffered WB write and block a same-cycle capture
//   csr_we_o/waddr_o/wdata_o   CSR file write port (addr/data are 0 when idle)
//   stall_wb_o       wb_req_i && !wb_ready_o
//   burst_err_o      sticky watchdog flag, cleared only by reset
//
// Optional feature macro: CSR_ARB_PERF_EN
//   When it is defined, the block adds perf_conflict_o[31:0], which counts
//   cycles where a WB write was captured into the buffer, and perf_stall_o[31:0],
//   which counts cycles with stall_wb_o=1. Both counters wrap.
// -----------------------------------------------------------------------------
module csr_wport_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_req_i,
  input  logic [11:0] trap_addr_i,
  input  logic [31:0] trap_data_i,
  input  logic        trap_last_i,
  input  logic        wb_req_i,
  input  logic [11:0] wb_addr_i,
  input  logic [31:0] wb_data_i,
  output logic        wb_ready_o,
  input  logic        flush_i,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_wb_o,
  output logic        burst_err_o
`ifdef CSR_ARB_PERF_EN
  ,
  output logic [31:0] perf_conflict_o,
  output logic [31:0] perf_stall_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [3:0] MAX_BEATS = 4'(MAX_BURST);

  state_e      state_q, state_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        buf_v_q, buf_v_d;
  logic [11:0] buf_addr_q, buf_addr_d;
  logic [31:0] buf_data_q, buf_data_d;
  logic        burst_err_q, burst_err_d;

  logic        in_burst_s;
  logic        buf_drain_s;
  logic        pass_s;
  logic        wb_ready_s;
  logic        capture_s;
  logic [3:0]  beat_inc_s;

`ifdef CSR_ARB_PERF_EN
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [31:0] perf_stall_q, perf_stall_d;
`endif

  // Port arbitration: trap beat > buffered write > WB pass-through.
  always_comb begin
    in_burst_s  = (state_q == ST_BURST);
    // The buffer drains only when the trap lock is released and no trap beat is
    // on the port. IDLE and DRAIN both behave this way.
    buf_drain_s = !rst && !trap_req_i && buf_v_q && !in_burst_s;
    // Pass-through is only possible with an empty buffer, so WB can never
    // overtake an older buffered write.
    pass_s      = !rst && !trap_req_i && !buf_v_q && !in_burst_s && wb_req_i;
    wb_ready_s  = !rst && (!buf_v_q || buf_drain_s);
    capture_s   = wb_req_i && wb_ready_s && !pass_s && !flush_i;

    csr_we_o    = 1'b0;
    csr_waddr_o = 12'h000;
    csr_wdata_o = 32'h0000_0000;
    if (rst) begin
      csr_we_o    = 1'b0;
    end else if (trap_req_i) begin
      csr_we_o    = 1'b1;
      csr_waddr_o = trap_addr_i;
      csr_wdata_o = trap_data_i;
    end else if (buf_drain_s) begin
      csr_we_o    = 1'b1;
      csr_waddr_o = buf_addr_q;
      csr_wdata_o = buf_data_q;
    end else if (pass_s) begin
      csr_we_o    = 1'b1;
      csr_waddr_o = wb_addr_i;
      csr_wdata_o = wb_data_i;
    end else begin
      csr_we_o    = 1'b0;
    end

    wb_ready_o  = wb_ready_s;
    stall_wb_o  = !rst && wb_req_i && !wb_ready_s;
    burst_err_o = !rst && burst_err_q;
  end

  // Next-state logic for the buffer, the lock FSM and the watchdog.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    buf_v_d     = buf_v_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    burst_err_d = burst_err_q;
    beat_inc_s  = beat_cnt_q + 4'd1;

    // Buffer: flush wins, otherwise refill, otherwise clear on drain.
    if (flush_i) begin
      buf_v_d = 1'b0;
    end else if (capture_s) begin
      buf_v_d    = 1'b1;
      buf_addr_d = wb_addr_i;
      buf_data_d = wb_data_i;
    end else if (buf_drain_s) begin
      buf_v_d = 1'b0;
    end else begin
      buf_v_d = buf_v_q;
    end

    case (state_q)
      ST_IDLE, ST_DRAIN: begin
        if (trap_req_i) begin
          if (trap_last_i) begin
            state_d    = buf_v_d ? ST_DRAIN : ST_IDLE;
            beat_cnt_d = 4'd0;
          end else begin
            state_d    = ST_BURST;
            beat_cnt_d = 4'd1;
          end
        end else begin
          state_d = buf_v_d ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_BURST: begin
        if (trap_req_i) begin
          // A burst that reaches MAX_BURST beats ends as if its last beat arrived.
          if (trap_last_i || (beat_inc_s == MAX_BEATS)) begin
            state_d    = buf_v_d ? ST_DRAIN : ST_IDLE;
            beat_cnt_d = 4'd0;
            if (!trap_last_i) begin
              burst_err_d = 1'b1;
            end else begin
              burst_err_d = burst_err_q;
            end
          end else begin
            beat_cnt_d = beat_inc_s;
          end
        end else begin
          state_d = ST_BURST;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        beat_cnt_d = 4'd0;
      end
    endcase
  end

`ifdef CSR_ARB_PERF_EN
  // Performance counters; they wrap naturally at 2^32.
  always_comb begin
    perf_conflict_d = capture_s  ? perf_conflict_q + 32'd1 : perf_conflict_q;
    perf_stall_d    = stall_wb_o ? perf_stall_q + 32'd1    : perf_stall_q;
    perf_conflict_o = perf_conflict_q;
    perf_stall_o    = perf_stall_q;
  end
`endif

  // State registers; reset abandons any burst and buffered write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      beat_cnt_q      <= 4'd0;
      buf_v_q         <= 1'b0;
      buf_addr_q      <= 12'h000;
      buf_data_q      <= 32'h0000_0000;
      burst_err_q     <= 1'b0;
`ifdef CSR_ARB_PERF_EN
      perf_conflict_q <= 32'd0;
      perf_stall_q    <= 32'd0;
`endif
    end else begin
      state_q         <= state_d;
      beat_cnt_q      <= beat_cnt_d;
      buf_v_q         <= buf_v_d;
      buf_addr_q      <= buf_addr_d;
      buf_data_q      <= buf_data_d;
      burst_err_q     <= burst_err_d;
`ifdef CSR_ARB_PERF_EN
      perf_conflict_q <= perf_conflict_d;
      perf_stall_q    <= perf_stall_d;
`endif
    end
  end

endmodule
